// File: rtl/fadd_rr_arb.sv
// Round-robin arbiter that shares one registered fadd adder among NREQ requesters.
// Optional build macro FADD_RR_ARB_OVF_EN adds a registered two's-complement overflow output rsp_ovf.

module fadd #(
  parameter int input_size = 2,
  parameter int depth      = 5,
  localparam int BW        = input_size**depth
) (
  input  logic [BW-1:0] in1,
  input  logic [BW-1:0] in2,
  input  logic          cin,
  output logic [BW-1:0] sum,
  output logic          cout
);

  assign {cout, sum} = {1'b0, in1} + {1'b0, in2} + {{BW{1'b0}}, cin};

endmodule

module fadd_rr_arb #(
  parameter int input_size = 2,
  parameter int depth      = 5,
  parameter int NREQ       = 4,
  localparam int BW        = input_size**depth
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*BW-1:0] req_in1,
  input  logic [NREQ*BW-1:0] req_in2,
  input  logic [NREQ-1:0]    req_cin,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [BW-1:0]      rsp_sum,
  output logic               rsp_cout,
  output logic [2:0]         rsp_id
`ifdef FADD_RR_ARB_OVF_EN
  ,
  output logic               rsp_ovf
`endif
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [2:0]    ptr_q;
  logic [7:0]    valid8, ready8;
  logic [3:0]    cand;
  logic [2:0]    gnt_idx;
  logic          gnt_any;
  logic          slot_free;
  logic          xfer;
  logic [BW-1:0] mux_in1, mux_in2, add_sum;
  logic          mux_cin, add_cout;

  assign valid8 = 8'(req_valid);

  // Rotating priority: scan NREQ candidates starting at ptr, wrapping at NREQ.
  always_comb begin
    // NOTE: every combinationally written signal gets a default first so no latch is inferred.
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_q} + 4'(k);
      if (cand >= 4'(NREQ)) cand = cand - 4'(NREQ);
      if (!gnt_any && valid8[cand[2:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand[2:0];
      end
    end
  end

  assign slot_free = !rst && ((state_q == EMPTY) || rsp_ready);
  assign xfer      = gnt_any && slot_free;
  assign ready8    = xfer ? (8'd1 << gnt_idx) : 8'd0;
  assign req_ready = ready8[NREQ-1:0];

  always_comb begin
    mux_in1 = '0;
    mux_in2 = '0;
    mux_cin = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == 3'(i)) begin
        mux_in1 = req_in1[i*BW +: BW];
        mux_in2 = req_in2[i*BW +: BW];
        mux_cin = req_cin[i];
      end
    end
  end

  fadd #(.input_size(input_size), .depth(depth)) u_fadd (
    .in1  (mux_in1),
    .in2  (mux_in2),
    .cin  (mux_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Result-slot FSM: state register, next-state logic, output logic.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (xfer) state_d = FULL;
      FULL:  if (xfer) state_d = FULL;
             else if (rsp_ready) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    rsp_valid = (state_q == FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (xfer) begin
      ptr_q <= (gnt_idx == 3'(NREQ-1)) ? 3'd0 : gnt_idx + 3'd1;
    end
  end

  // The result registers are reset too, so a discarded result never reappears after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_sum  <= '0;
      rsp_cout <= 1'b0;
      rsp_id   <= '0;
    end else if (xfer) begin
      rsp_sum  <= add_sum;
      rsp_cout <= add_cout;
      rsp_id   <= gnt_idx;
    end
  end

`ifdef FADD_RR_ARB_OVF_EN
  logic carry_msb;
  assign carry_msb = mux_in1[BW-1] ^ mux_in2[BW-1] ^ add_sum[BW-1];

  always_ff @(posedge clk) begin
    if (rst)       rsp_ovf <= 1'b0;
    else if (xfer) rsp_ovf <= carry_msb ^ add_cout;
  end
`endif

endmodule

// File: tb/tb_fadd_rr_arb.sv
// Directed bench for fadd_rr_arb: per-cycle comparison against a behavioural model,
// plus hand-computed expectations for reset, single op, round robin, backpressure, wrap and mid-op reset.

module tb_fadd_rr_arb;

  localparam int NREQ = 4;
  localparam int BW   = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*BW-1:0] req_in1, req_in2;
  logic [NREQ-1:0]    req_cin;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [BW-1:0]      rsp_sum;
  logic               rsp_cout;
  logic [2:0]         rsp_id;
`ifdef FADD_RR_ARB_OVF_EN
  logic               rsp_ovf;
`endif

  int errors = 0;
  int checks = 0;

  fadd_rr_arb #(.input_size(2), .depth(5), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_in1   (req_in1),
    .req_in2   (req_in2),
    .req_cin   (req_cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_id    (rsp_id)
`ifdef FADD_RR_ARB_OVF_EN
    ,
    .rsp_ovf   (rsp_ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model of the arbiter and result slot.
  bit          m_init = 0;
  bit          m_full;
  int          m_ptr;
  logic [31:0] m_sum;
  logic        m_cout;
  int          m_id;
  logic        m_ovf;

  function automatic logic [NREQ-1:0] exp_grant();
    logic [NREQ-1:0] g = '0;
    if (rst || (m_full && !rsp_ready)) return g;
    for (int k = 0; k < NREQ; k++) begin
      int i = (m_ptr + k) % NREQ;
      if (req_valid[i]) begin
        g[i] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  always @(posedge clk) begin
    logic [NREQ-1:0] g;
    logic [32:0]     full_sum;
    logic [31:0]     a, b;
    g = exp_grant();
    if (rst) begin
      m_init = 1;
      m_full = 0; m_ptr = 0; m_sum = '0; m_cout = 0; m_id = 0; m_ovf = 0;
    end else if (g != '0) begin
      for (int i = 0; i < NREQ; i++) begin
        if (g[i]) begin
          a        = req_in1[i*BW +: BW];
          b        = req_in2[i*BW +: BW];
          full_sum = 33'(a) + 33'(b) + 33'(req_cin[i]);
          m_sum    = full_sum[31:0];
          m_cout   = full_sum[32];
          m_ovf    = (a[31] == b[31]) && (m_sum[31] != a[31]);
          m_id     = i;
          m_ptr    = (i + 1) % NREQ;
          m_full   = 1;
        end
      end
    end else if (rsp_ready) begin
      m_full = 0;
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      check("model_req_ready", 64'(req_ready), 64'(exp_grant()));
      check("model_rsp_valid", 64'(rsp_valid), 64'(m_full));
      check("model_rsp_sum",   64'(rsp_sum),   64'(m_sum));
      check("model_rsp_cout",  64'(rsp_cout),  64'(m_cout));
      check("model_rsp_id",    64'(rsp_id),    64'(m_id));
`ifdef FADD_RR_ARB_OVF_EN
      check("model_rsp_ovf",   64'(rsp_ovf),   64'(m_ovf));
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic [31:0] a, input logic [31:0] b, input logic c);
    req_in1[i*BW +: BW] = a;
    req_in2[i*BW +: BW] = b;
    req_cin[i]          = c;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '1;
    req_in1   = '0;
    req_in2   = '0;
    req_cin   = '0;
    rsp_ready = 1'b1;

    // Reset held two cycles with every requester asking.
    repeat (2) begin
      step();
      #2;
      check("rst_req_ready", 64'(req_ready), 64'h0);
      check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
      check("rst_rsp_sum",   64'(rsp_sum),   64'h0);
    end

    // Single op from requester 2.
    step();
    rst       = 1'b0;
    req_valid = 4'b0100;
    set_lane(2, 32'h0000_0005, 32'h0000_0003, 1'b1);
    #2;
    check("single_grant", 64'(req_ready), 64'b0100);
    step();
    req_valid = '0;
    #2;
    check("single_valid", 64'(rsp_valid), 64'h1);
    check("single_sum",   64'(rsp_sum),   64'h9);
    check("single_cout",  64'(rsp_cout),  64'h0);
    check("single_id",    64'(rsp_id),    64'h2);

    // Reset again so the pointer restarts at 0 for the rotation test.
    rst = 1'b1;
    step();
    rst       = 1'b0;
    req_valid = 4'b1111;
    for (int i = 0; i < NREQ; i++) set_lane(i, 32'h11 + 32'(i) * 32'h1000, 32'h100, 1'(i % 2));
    for (int c = 0; c < 5; c++) begin
      #2;
      check("rr_grant", 64'(req_ready), 64'(1) << (c % 4));
      if (c > 0) check("rr_id", 64'(rsp_id), 64'(c - 1));
      step();
    end

    // Backpressure: slot FULL with requester 0's result, consumer stalls three cycles.
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    repeat (3) begin
      #2;
      check("bp_req_ready", 64'(req_ready), 64'h0);
      check("bp_valid",     64'(rsp_valid), 64'h1);
      check("bp_id",        64'(rsp_id),    64'h0);
      check("bp_sum",       64'(rsp_sum),   64'h111);
      step();
    end
    rsp_ready = 1'b1;
    #2;
    check("bp_release_grant", 64'(req_ready), 64'b0010);
    step();
    req_valid = '0;
    #2;
    check("bp_new_id",  64'(rsp_id),  64'h1);
    check("bp_new_sum", 64'(rsp_sum), 64'h1112);

    // Wrap: all-ones + 0 + 1 from requester 3.
    set_lane(3, 32'hFFFF_FFFF, 32'h0, 1'b1);
    req_valid = 4'b1000;
    #2;
    check("wrap_grant", 64'(req_ready), 64'b1000);
    step();
    req_valid = '0;
    #2;
    check("wrap_sum",  64'(rsp_sum),  64'h0);
    check("wrap_cout", 64'(rsp_cout), 64'h1);
    check("wrap_id",   64'(rsp_id),   64'h3);
`ifdef FADD_RR_ARB_OVF_EN
    check("wrap_ovf",  64'(rsp_ovf),  64'h0);
`endif

    // Signed overflow: 0x7FFF_FFFF + 1 from requester 0.
    set_lane(0, 32'h7FFF_FFFF, 32'h1, 1'b0);
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    #2;
    check("ovf_sum",  64'(rsp_sum),  64'h8000_0000);
    check("ovf_cout", 64'(rsp_cout), 64'h0);
`ifdef FADD_RR_ARB_OVF_EN
    check("ovf_flag", 64'(rsp_ovf),  64'h1);
`endif

    // Reset mid-operation while the consumer stalls a held result.
    rsp_ready = 1'b0;
    step();
    rst = 1'b1;
    #2;
    check("midrst_ready", 64'(req_ready), 64'h0);
    step();
    rst       = 1'b0;
    req_valid = 4'b1010;
    set_lane(1, 32'h20, 32'h22, 1'b0);
    #2;
    check("midrst_valid", 64'(rsp_valid), 64'h0);
    check("midrst_sum",   64'(rsp_sum),   64'h0);
    check("midrst_grant", 64'(req_ready), 64'b0010);
    step();
    req_valid = '0;
    #2;
    check("midrst_id",  64'(rsp_id),  64'h1);
    check("midrst_res", 64'(rsp_sum), 64'h42);
    rsp_ready = 1'b1;
    step();
    #2;
    check("drain_valid", 64'(rsp_valid), 64'h0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fadd_rr_arb.md
FADD_RR_ARB -- requirements
Module: fadd_rr_arb

Interface
REQ-001 Parameter input_size, default 2: fadd radix, passed unchanged to the internal fadd instance.
REQ-002 Parameter depth, default 5: fadd tree depth; operand width BW = input_size**depth (default 32).
REQ-003 Parameter NREQ, default 4: number of requesters; legal range 2..8.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req_valid  input  NREQ  per-requester operation request; bit i belongs to requester i.
REQ-007 req_ready  output  NREQ  one-hot grant/accept; at most one bit high per cycle.
REQ-008 req_in1  input  NREQ*BW  operand A; requester i occupies bits [i*BW +: BW].
REQ-009 req_in2  input  NREQ*BW  operand B, same packing as req_in1.
REQ-010 req_cin  input  NREQ  carry-in, bit i for requester i.
REQ-011 rsp_valid  output  1  result register holds a valid result.
REQ-012 rsp_ready  input  1  consumer accepts the result.
REQ-013 rsp_sum  output  BW  registered sum.
REQ-014 rsp_cout  output  1  registered carry-out.
REQ-015 rsp_id  output  3  index of the requester that produced the result.

Function
REQ-016 One fadd instance (input_size, depth) shall be shared by all requesters; the arbiter mux drives its in1/in2/cin from the granted requester.
REQ-017 Result register states: EMPTY (rsp_valid=0), FULL (rsp_valid=1).
REQ-018 Slot free = EMPTY, or FULL with rsp_ready=1 in the same cycle.
REQ-019 When slot free and any req_valid high, req_ready shall assert combinationally for exactly one requester: first valid index at or after pointer ptr, wrapping from NREQ-1 to 0.
REQ-020 A transfer occurs when req_valid[i] and req_ready[i] are both high; on that edge result register loads fadd sum/cout, rsp_id loads i, state becomes FULL.
REQ-021 Latency: request accepted in cycle N -> rsp_valid high in cycle N+1.
REQ-022 After a transfer to requester i, ptr shall become (i+1) mod NREQ; ptr unchanged otherwise.
REQ-023 FULL with rsp_ready=1 and no request: state becomes EMPTY on the edge.
REQ-024 FULL with rsp_ready=1 and a request: back-to-back, state stays FULL with new result; throughput one op per cycle.
REQ-025 FULL with rsp_ready=0: all req_ready low; rsp_sum/rsp_cout/rsp_id/rsp_valid held stable.
REQ-026 req_ready shall not depend on req_valid of non-granted requesters beyond priority selection; no request lost or duplicated.
REQ-027 Sum arithmetic: {rsp_cout, rsp_sum} = in1 + in2 + cin, modulo 2**(BW+1); all-ones + 0 + cin=1 gives sum 0, cout 1.
REQ-028 Requester holding req_valid shall be granted within NREQ transfers (starvation-free).

Reset
REQ-029 On rst=1 at a clock edge: state EMPTY, rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, ptr=0.
REQ-030 While rst=1, req_ready shall be all zero; reset mid-operation discards any held result without a handshake.

Configuration
REQ-031 Macro FADD_RR_ARB_OVF_EN: when defined, adds output rsp_ovf (1 bit), registered with the result, = carry into MSB XOR carry out (two's-complement overflow), reset 0.
REQ-032 Without FADD_RR_ARB_OVF_EN, port rsp_ovf and its logic shall not exist; all other behaviour identical.

Verification
REQ-033 Reset: assert rst 2 cycles with all req_valid=1 -> req_ready=0, rsp_valid=0, rsp_sum=0 throughout.
REQ-034 Single op: req 2 valid, in1=0x0000_0005, in2=0x0000_0003, cin=1, rsp_ready=1 -> next cycle rsp_valid=1, rsp_sum=0x9, rsp_cout=0, rsp_id=2.
REQ-035 Round robin: all 4 valid continuously, rsp_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; rsp_id follows one cycle later.
REQ-036 Backpressure: result FULL, rsp_ready=0 for 3 cycles with req 1 valid -> req_ready=0, outputs stable; rsp_ready=1 -> same cycle grant to 1, new result next cycle.
REQ-037 Wrap: in1=0xFFFF_FFFF, in2=0, cin=1 -> rsp_sum=0, rsp_cout=1; with FADD_RR_ARB_OVF_EN, in1=0x7FFF_FFFF, in2=1, cin=0 -> rsp_ovf=1.
REQ-038 Reset mid-op: rst during FULL with rsp_ready=0 -> next cycle rsp_valid=0, ptr=0 (first grant after release goes to lowest valid index).
